windowed_peak_detector: RTL and testbench

// - Parametrised successor of the ADC-path peak detector.
// - Takes multi-lane ADC words (LANES signed samples per beat) and finds the peak sample over a
//   run-time window of 1..MAX_WIN beats.
// - Selection mode: absolute magnitude or signed maximum.
// - Emits the raw signed peak sample and its position (beat, lane) once per window.
// - Sits between the input shifter and the input lookup table in the ADC driver.

---
 rtl/windowed_peak_detector_pkg.sv | 13 +
 rtl/windowed_peak_detector_lane_reduce.sv | 62 ++++++
 rtl/windowed_peak_detector.sv | 242 ++++++++++++++++++++++++
 tb/tb_windowed_peak_detector.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/windowed_peak_detector_pkg.sv
// ising_config: shared types and constants for the ADC-path blocks.
//   peak_mode_t  - peak selection mode (absolute magnitude / signed maximum)
//   pk_state_t   - window FSM states of windowed_peak_detector
//   PEAK_LATENCY - register stages from the accepted last beat to peak_valid
package ising_config;

  typedef enum logic {PK_MODE_ABS, PK_MODE_SIGNED} peak_mode_t;

  typedef enum logic {PK_IDLE, PK_ACC} pk_state_t;

  localparam int PEAK_LATENCY = 3;

endpackage

// File: rtl/windowed_peak_detector_lane_reduce.sv
// peak_lane_reduce: stage-2 compare tree over LANES keys, registered output.
//   clk    in   clock (posedge)
//   i_key  in   LANES packed unsigned compare keys
//   i_raw  in   LANES packed raw signed samples, same lane order
//   o_key  out  best key (registered)
//   o_raw  out  raw sample of the best lane (registered)
//   o_lane out  index of the best lane; ties resolve to the lower lane
module peak_lane_reduce #(
  parameter int SAMPLE_W = 16,
  parameter int LANES    = 8,
  localparam int LANE_W  = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic [LANES*SAMPLE_W-1:0] i_key,
  input  logic [LANES*SAMPLE_W-1:0] i_raw,
  output logic [SAMPLE_W-1:0]       o_key,
  output logic [SAMPLE_W-1:0]       o_raw,
  output logic [LANE_W-1:0]         o_lane
);

  // level 0 holds the inputs; level LANE_W slot 0 holds the winner
  logic [SAMPLE_W-1:0] w_key  [LANE_W+1][LANES];
  logic [SAMPLE_W-1:0] w_raw  [LANE_W+1][LANES];
  logic [LANE_W-1:0]   w_lane [LANE_W+1][LANES];

  always_comb begin
    for (int unsigned l = 0; l <= LANE_W; l++) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        w_key[l][i]  = '0;
        w_raw[l][i]  = '0;
        w_lane[l][i] = '0;
      end
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      w_key[0][i]  = i_key[i*SAMPLE_W +: SAMPLE_W];
      w_raw[0][i]  = i_raw[i*SAMPLE_W +: SAMPLE_W];
      w_lane[0][i] = LANE_W'(i);
    end
    // even slot always carries the lower lane range, so only a strictly
    // greater odd slot may win
    for (int unsigned l = 0; l < LANE_W; l++) begin
      for (int unsigned i = 0; i < (LANES >> (l + 1)); i++) begin
        if (w_key[l][2*i+1] > w_key[l][2*i]) begin
          w_key[l+1][i]  = w_key[l][2*i+1];
          w_raw[l+1][i]  = w_raw[l][2*i+1];
          w_lane[l+1][i] = w_lane[l][2*i+1];
        end else begin
          w_key[l+1][i]  = w_key[l][2*i];
          w_raw[l+1][i]  = w_raw[l][2*i];
          w_lane[l+1][i] = w_lane[l][2*i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    o_key  <= w_key[LANE_W][0];
    o_raw  <= w_raw[LANE_W][0];
    o_lane <= w_lane[LANE_W][0];
  end

endmodule

// File: rtl/windowed_peak_detector.sv
// windowed_peak_detector: finds the peak sample over a run-time window of
// 1..MAX_WIN multi-lane ADC beats, by magnitude or by signed value.
//   clk, rst        clock, synchronous active-high reset
//   s_tdata         LANES signed samples per beat; s_tvalid marks a beat
//   run             beats are accepted only while high; drop aborts a window
//   cfg_window_len  window length (0 -> 1, > MAX_WIN -> MAX_WIN)
//   cfg_mode        0 = max |x|, 1 = max signed x (latched per window)
//   peak_out/beat/lane  raw peak sample and its position, held between pulses
//   peak_valid      one-cycle pulse per completed window
//   busy            window open or tagged beats still in the pipeline
module windowed_peak_detector
  import ising_config::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int LANES    = 8,
  parameter int MAX_WIN  = 64,
  localparam int BEAT_W  = $clog2(MAX_WIN),
  localparam int LANE_W  = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*SAMPLE_W-1:0] s_tdata,
  input  logic                      s_tvalid,
  input  logic                      run,
  input  logic [BEAT_W:0]           cfg_window_len,
  input  logic                      cfg_mode,
  output logic [SAMPLE_W-1:0]       peak_out,
  output logic [BEAT_W-1:0]         peak_beat,
  output logic [LANE_W-1:0]         peak_lane,
  output logic                      peak_valid,
  output logic                      busy
);

  pk_state_t   r_state, w_state_nxt;
  logic [BEAT_W-1:0] r_cnt;
  logic [BEAT_W:0]   r_len, w_len_clamped;
  peak_mode_t  r_mode, w_mode;
  logic        r_cur_id, w_tag_id;
  logic        w_take, w_first, w_last, w_start, w_abort;
  logic [BEAT_W-1:0] w_beat_idx;

  always_comb begin
    if (cfg_window_len == '0)
      w_len_clamped = (BEAT_W+1)'(1);
    else if (cfg_window_len > (BEAT_W+1)'(MAX_WIN))
      w_len_clamped = (BEAT_W+1)'(MAX_WIN);
    else
      w_len_clamped = cfg_window_len;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= PK_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_first     = 1'b0;
    w_last      = 1'b0;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_beat_idx  = '0;
    unique case (r_state)
      PK_IDLE: begin
        if (s_tvalid && run) begin
          w_take  = 1'b1;
          w_first = 1'b1;
          w_start = 1'b1;
          if (w_len_clamped == (BEAT_W+1)'(1)) w_last = 1'b1;
          else                                 w_state_nxt = PK_ACC;
        end
      end
      PK_ACC: begin
        if (!run) begin
          w_abort     = 1'b1;
          w_state_nxt = PK_IDLE;
        end else if (s_tvalid) begin
          w_take     = 1'b1;
          w_beat_idx = r_cnt;
          if ({1'b0, r_cnt} == r_len - (BEAT_W+1)'(1)) begin
            w_last      = 1'b1;
            w_state_nxt = PK_IDLE;
          end
        end
      end
      default: w_state_nxt = PK_IDLE;
    endcase
  end

  // One-bit window id: at most the open window and its finished predecessor
  // share the pipeline, so an abort discards exactly the entries whose id
  // matches the open window (a finished result in stage 3 is never dropped).
  assign w_tag_id = w_start ? ~r_cur_id : r_cur_id;
  assign w_mode   = w_start ? peak_mode_t'(cfg_mode) : r_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_len    <= '0;
      r_mode   <= PK_MODE_ABS;
      r_cur_id <= 1'b0;
    end else if (w_start) begin
      r_cnt    <= BEAT_W'(1);
      r_len    <= w_len_clamped;
      r_mode   <= peak_mode_t'(cfg_mode);
      r_cur_id <= ~r_cur_id;
    end else if (w_take) begin
      r_cnt <= r_cnt + BEAT_W'(1);
    end
  end

  // Stage 1: per-lane unsigned compare key
  logic [LANES*SAMPLE_W-1:0] w_key_flat;
  always_comb begin
    w_key_flat = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (w_mode == PK_MODE_SIGNED)
        w_key_flat[i*SAMPLE_W +: SAMPLE_W] =
          {~s_tdata[i*SAMPLE_W + SAMPLE_W - 1], s_tdata[i*SAMPLE_W +: SAMPLE_W-1]};
      else if (s_tdata[i*SAMPLE_W + SAMPLE_W - 1])
        w_key_flat[i*SAMPLE_W +: SAMPLE_W] = ~s_tdata[i*SAMPLE_W +: SAMPLE_W] + SAMPLE_W'(1);
      else
        w_key_flat[i*SAMPLE_W +: SAMPLE_W] = s_tdata[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  logic                      r_s1_vld, r_s1_first, r_s1_last, r_s1_id;
  logic [BEAT_W-1:0]         r_s1_beat;
  logic [LANES*SAMPLE_W-1:0] r_s1_key, r_s1_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_id    <= 1'b0;
      r_s1_beat  <= '0;
      r_s1_key   <= '0;
      r_s1_raw   <= '0;
    end else begin
      r_s1_vld <= w_take;
      if (w_take) begin
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
        r_s1_id    <= w_tag_id;
        r_s1_beat  <= w_beat_idx;
        r_s1_key   <= w_key_flat;
        r_s1_raw   <= s_tdata;
      end
    end
  end

  // Stage 2: lane reduction (data in sub-module, tags alongside here)
  logic [SAMPLE_W-1:0] w_s2_key, w_s2_raw;
  logic [LANE_W-1:0]   w_s2_lane;

  peak_lane_reduce #(
    .SAMPLE_W (SAMPLE_W),
    .LANES    (LANES)
  ) u_reduce (
    .clk    (clk),
    .i_key  (r_s1_key),
    .i_raw  (r_s1_raw),
    .o_key  (w_s2_key),
    .o_raw  (w_s2_raw),
    .o_lane (w_s2_lane)
  );

  logic              r_s2_vld, r_s2_first, r_s2_last, r_s2_id;
  logic [BEAT_W-1:0] r_s2_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld   <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_id    <= 1'b0;
      r_s2_beat  <= '0;
    end else begin
      r_s2_vld   <= r_s1_vld && !(w_abort && (r_s1_id == r_cur_id));
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_id    <= r_s1_id;
      r_s2_beat  <= r_s1_beat;
    end
  end

  // Stage 3: window accumulator
  logic                r_acc_vld, r_acc_done, r_acc_id;
  logic [SAMPLE_W-1:0] r_acc_key, r_acc_raw;
  logic [BEAT_W-1:0]   r_acc_beat;
  logic [LANE_W-1:0]   r_acc_lane;
  logic                w_kill_s2, w_kill_acc;

  assign w_kill_s2  = w_abort && (r_s2_id == r_cur_id);
  assign w_kill_acc = w_abort && r_acc_vld && !r_acc_done && (r_acc_id == r_cur_id);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_vld  <= 1'b0;
      r_acc_done <= 1'b0;
      r_acc_id   <= 1'b0;
      r_acc_key  <= '0;
      r_acc_raw  <= '0;
      r_acc_beat <= '0;
      r_acc_lane <= '0;
    end else if (r_s2_vld && !w_kill_s2) begin
      r_acc_vld  <= 1'b1;
      r_acc_done <= r_s2_last;
      r_acc_id   <= r_s2_id;
      if (r_s2_first || (w_s2_key > r_acc_key)) begin
        r_acc_key  <= w_s2_key;
        r_acc_raw  <= w_s2_raw;
        r_acc_beat <= r_s2_beat;
        r_acc_lane <= w_s2_lane;
      end
    end else if (r_acc_done || w_kill_acc) begin
      r_acc_vld  <= 1'b0;
      r_acc_done <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_valid <= 1'b0;
      peak_out   <= '0;
      peak_beat  <= '0;
      peak_lane  <= '0;
    end else begin
      peak_valid <= r_acc_vld && r_acc_done;
      if (r_acc_vld && r_acc_done) begin
        peak_out  <= r_acc_raw;
        peak_beat <= r_acc_beat;
        peak_lane <= r_acc_lane;
      end
    end
  end

  assign busy = (r_state == PK_ACC) || r_s1_vld || r_s2_vld || r_acc_vld;

endmodule

// File: tb/tb_windowed_peak_detector.sv
module tb_windowed_peak_detector;
  import ising_config::*;

  localparam int SAMPLE_W = 16;
  localparam int LANES    = 8;
  localparam int MAX_WIN  = 64;
  localparam int BEAT_W   = 6;
  localparam int LANE_W   = 3;
  localparam int DW       = LANES * SAMPLE_W;

  logic              clk;
  logic              rst;
  logic [DW-1:0]     s_tdata;
  logic              s_tvalid;
  logic              run;
  logic [BEAT_W:0]   cfg_window_len;
  logic              cfg_mode;
  logic [SAMPLE_W-1:0] peak_out;
  logic [BEAT_W-1:0] peak_beat;
  logic [LANE_W-1:0] peak_lane;
  logic              peak_valid;
  logic              busy;

  windowed_peak_detector #(
    .SAMPLE_W (SAMPLE_W),
    .LANES    (LANES),
    .MAX_WIN  (MAX_WIN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .run            (run),
    .cfg_window_len (cfg_window_len),
    .cfg_mode       (cfg_mode),
    .peak_out       (peak_out),
    .peak_beat      (peak_beat),
    .peak_lane      (peak_lane),
    .peak_valid     (peak_valid),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int          t;
    logic [15:0] pk;
    int          beat;
    int          lane;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_beats[$];
  bit            m_active = 0;
  int            m_len    = 1;
  bit            m_mode   = 0;
  logic [15:0]   h_pk     = '0;
  int            h_beat   = 0;
  int            h_lane   = 0;
  bit            mon_en   = 0;

  function automatic int score(input logic [15:0] x, input bit md);
    int s;
    s = $signed(x);
    if (md) return s;
    return (s < 0) ? -s : s;
  endfunction

  task automatic close_window(input int e);
    exp_t ex;
    int best, v;
    logic [DW-1:0] d;
    logic [15:0] x;
    best = 0;
    ex.t = e + PEAK_LATENCY;
    ex.pk = '0;
    ex.beat = 0;
    ex.lane = 0;
    for (int b = 0; b < m_beats.size(); b++) begin
      d = m_beats[b];
      for (int l = 0; l < LANES; l++) begin
        x = d[l*16 +: 16];
        v = score(x, m_mode);
        if ((b == 0 && l == 0) || v > best) begin
          best = v;
          ex.pk = x;
          ex.beat = b;
          ex.lane = l;
        end
      end
    end
    exp_q.push_back(ex);
    m_beats.delete();
    m_active = 0;
  endtask

  task automatic model_edge(input bit v, input bit r, input logic [DW-1:0] d,
                            input logic [BEAT_W:0] len, input bit md, input bit rs);
    if (rs) begin
      m_beats.delete();
      m_active = 0;
      exp_q.delete();
      h_pk = '0;
      h_beat = 0;
      h_lane = 0;
    end else if (m_active && !r) begin
      m_beats.delete();
      m_active = 0;
    end else if (v && r) begin
      if (!m_active) begin
        m_len = (len == 0) ? 1 : ((int'(len) > MAX_WIN) ? MAX_WIN : int'(len));
        m_mode = md;
        m_active = 1;
      end
      m_beats.push_back(d);
      if (m_beats.size() == m_len) close_window(cyc);
    end
  endtask

  // ---------------- per-cycle output monitor ----------------
  always @(negedge clk) begin
    bit ev;
    ev = 0;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].t < cyc) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
        ev = 1;
        h_pk = exp_q[0].pk;
        h_beat = exp_q[0].beat;
        h_lane = exp_q[0].lane;
        void'(exp_q.pop_front());
      end
      checks++;
      assert (peak_valid === ev) else begin
        errors++;
        $error("FAIL mon_valid cyc=%0d got=%b exp=%b", cyc, peak_valid, ev);
      end
      checks++;
      assert (peak_out === h_pk) else begin
        errors++;
        $error("FAIL mon_peak_out cyc=%0d got=%h exp=%h", cyc, peak_out, h_pk);
      end
      checks++;
      assert (int'(peak_beat) === h_beat) else begin
        errors++;
        $error("FAIL mon_peak_beat cyc=%0d got=%0d exp=%0d", cyc, peak_beat, h_beat);
      end
      checks++;
      assert (int'(peak_lane) === h_lane) else begin
        errors++;
        $error("FAIL mon_peak_lane cyc=%0d got=%0d exp=%0d", cyc, peak_lane, h_lane);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [BEAT_W:0] g_len  = 1;
  bit              g_mode = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input bit r, input logic [DW-1:0] d,
                       input logic [BEAT_W:0] len, input bit md, input bit rs);
    s_tvalid = v;
    run = r;
    s_tdata = d;
    cfg_window_len = len;
    cfg_mode = md;
    rst = rs;
    @(posedge clk);
    #1;
    model_edge(v, r, d, len, md, rs);
  endtask

  task automatic beat(input logic [DW-1:0] d);
    drive(1, 1, d, g_len, g_mode, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1, '0, g_len, g_mode, 0);
  endtask

  function automatic logic [DW-1:0] mk(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
    return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic logic [15:0] rsamp();
    case ($urandom_range(0, 4))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'($urandom_range(0, 8)) - 16'd4;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [DW-1:0] rbeat();
    logic [DW-1:0] d;
    for (int l = 0; l < LANES; l++) d[l*16 +: 16] = rsamp();
    return d;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    s_tvalid = 0; run = 0; s_tdata = '0; cfg_window_len = '0; cfg_mode = 0; rst = 1;
    drive(0, 0, '0, 1, 0, 1);
    mon_en = 1;
    drive(0, 0, '0, 1, 0, 1);
    chk("rst_valid", 32'(peak_valid), 0);
    chk("rst_peak_out", 32'(peak_out), 0);
    chk("rst_beat", 32'(peak_beat), 0);
    chk("rst_lane", 32'(peak_lane), 0);
    chk("rst_busy", 32'(busy), 0);
    drive(0, 1, '0, 1, 0, 0);

    // T1: single-beat window, magnitude mode
    g_len = 1; g_mode = 0;
    beat(mk(100, -200, 50, 0, 0, 0, 0, 0));
    idle(2);
    chk("t1_not_early", 32'(peak_valid), 0);
    idle(1);
    chk("t1_valid", 32'(peak_valid), 1);
    chk("t1_out", 32'(peak_out), 32'h0000FF38);
    chk("t1_lane", 32'(peak_lane), 1);
    chk("t1_beat", 32'(peak_beat), 0);
    idle(1);
    chk("t1_single_pulse", 32'(peak_valid), 0);

    // T2: -32768 outranks 0x7FFF by magnitude
    g_len = 4; g_mode = 0;
    beat(mk(1, 2, 3, 4, 5, 6, 7, 8));
    beat(mk(-9, 9, -9, 9, 0, 0, 0, 0));
    beat(mk(10, 11, 12, 13, 14, 15, 16, 32767));
    beat(mk(-32768, 1, 1, 1, 1, 1, 1, 1));
    idle(3);
    chk("t2_valid", 32'(peak_valid), 1);
    chk("t2_out", 32'(peak_out), 32'h00008000);
    chk("t2_beat", 32'(peak_beat), 3);
    chk("t2_lane", 32'(peak_lane), 0);

    // T3: signed mode, repeated maximum -> earliest beat wins
    g_len = 4; g_mode = 1;
    beat(mk(-100, -90, -80, -70, -60, -50, -40, -30));
    beat(mk(-50, -50, -50, -50, -3, -50, -50, -50));
    beat(mk(-10, -10, -10, -10, -10, -10, -10, -10));
    beat(mk(-20, -20, -3, -20, -20, -20, -20, -20));
    idle(3);
    chk("t3_valid", 32'(peak_valid), 1);
    chk("t3_out", 32'(peak_out), 32'h0000FFFD);
    chk("t3_beat", 32'(peak_beat), 1);
    chk("t3_lane", 32'(peak_lane), 4);

    // T4: 8-beat window with gaps; busy stays high throughout
    g_len = 8; g_mode = 0;
    for (int k = 0; k < 8; k++) begin
      beat(rbeat());
      chk("t4_busy_beat", 32'(busy), 1);
      if (k < 7) begin
        repeat ($urandom_range(0, 3)) begin
          idle(1);
          chk("t4_busy_gap", 32'(busy), 1);
        end
      end
    end
    idle(2);
    chk("t4_busy_tail", 32'(busy), 1);
    chk("t4_no_early", 32'(peak_valid), 0);
    idle(1);
    chk("t4_valid", 32'(peak_valid), 1);
    chk("t4_busy_done", 32'(busy), 0);

    // T5: abort after 5 of 8 beats, then a fresh 2-beat window
    g_len = 8; g_mode = 0;
    for (int k = 0; k < 5; k++) beat(mk(32767, -32768, 32767, 0, 0, 0, 0, 0));
    drive(0, 0, '0, g_len, g_mode, 0);
    chk("t5_busy_abort", 32'(busy), 0);
    g_len = 2;
    beat(mk(1, 2, 3, 4, 5, 6, 7, -8));
    beat(mk(3, 3, 3, 3, 3, 3, 3, 3));
    idle(3);
    chk("t5_valid", 32'(peak_valid), 1);
    chk("t5_out", 32'(peak_out), 32'h0000FFF8);
    chk("t5_lane", 32'(peak_lane), 7);

    // T6: length 0 -> 1 beat; 200 on the 7-bit port reads as 72 -> clamped to 64
    g_len = 0; g_mode = 1;
    beat(rbeat());
    idle(3);
    chk("t6_len0_valid", 32'(peak_valid), 1);
    g_len = 7'd72; g_mode = 0;
    for (int k = 0; k < 64; k++) beat(rbeat());
    idle(3);
    chk("t6_len64_valid", 32'(peak_valid), 1);
    idle(2);

    // reset mid-window
    g_len = 8;
    for (int k = 0; k < 3; k++) beat(rbeat());
    drive(0, 1, '0, g_len, g_mode, 1);
    chk("t6_rst_valid", 32'(peak_valid), 0);
    chk("t6_rst_out", 32'(peak_out), 0);
    chk("t6_rst_beat", 32'(peak_beat), 0);
    chk("t6_rst_lane", 32'(peak_lane), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    idle(4);
    g_len = 3; g_mode = 1;
    for (int k = 0; k < 3; k++) beat(rbeat());
    idle(3);
    chk("t6_post_rst_valid", 32'(peak_valid), 1);

    // random windows: gaps, aborts, back-to-back, cfg changes mid-window
    for (int w = 0; w < 40; w++) begin
      int n;
      g_len = 7'($urandom_range(0, 10));
      g_mode = bit'($urandom_range(0, 1));
      n = (g_len == 0) ? 1 : int'(g_len);
      for (int k = 0; k < n; k++) begin
        beat(rbeat());
        g_len = 7'($urandom_range(0, 127));
        g_mode = bit'($urandom_range(0, 1));
        if (k < n - 1) begin
          if ($urandom_range(0, 11) == 0) begin
            drive(0, 0, '0, g_len, g_mode, 0);
            break;
          end
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
    end
    idle(6);
    chk("end_queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
